// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 window generator for raster-order pixels.
// Two line buffers plus a 3x3 shift register produce nine window taps per
// accepted pixel. A window is published only when it is complete and lies on
// the configured stride grid. Pixel values pass through untouched.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   Data_In, Valid_In        pixel stream, no backpressure
//   Data_Out0..Data_Out8     window taps, row-major, 0 = top-left, 8 = bottom-right
//   Valid_Out                one-cycle pulse per complete window
//   Frame_Done               pulses on the cycle after the last pixel of a frame
module window_gen_3x3 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Valid_In,
  output logic [DATA_W-1:0] Data_Out0,
  output logic [DATA_W-1:0] Data_Out1,
  output logic [DATA_W-1:0] Data_Out2,
  output logic [DATA_W-1:0] Data_Out3,
  output logic [DATA_W-1:0] Data_Out4,
  output logic [DATA_W-1:0] Data_Out5,
  output logic [DATA_W-1:0] Data_Out6,
  output logic [DATA_W-1:0] Data_Out7,
  output logic [DATA_W-1:0] Data_Out8,
  output logic              Valid_Out,
  output logic              Frame_Done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // Line buffers: lb0 holds the previous row, lb1 the row before that.
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  // Phase bits track parity of (col-2) and (row-2); 0 means on the stride-2 grid.
  logic              col_ph_q, col_ph_d;
  logic              row_ph_q, row_ph_d;
  logic [DATA_W-1:0] sr_q   [9];
  logic [DATA_W-1:0] sr_d   [9];
  logic [DATA_W-1:0] dout_q [9];
  logic [DATA_W-1:0] dout_d [9];
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic              col_end_c;
  logic              row_end_c;
  logic              win_ok_c;

  assign col_end_c = (col_q == COL_LAST);
  assign row_end_c = (row_q == ROW_LAST);
  assign win_ok_c  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2)) &&
                     ((STRIDE == 1) || (!col_ph_q && !row_ph_q));

  // Next-state: window shift, counters, phases and output capture.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    sr_d     = sr_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    if (Valid_In) begin
      for (int r = 0; r < 3; r++) begin
        sr_d[r*3]     = sr_q[r*3 + 1];
        sr_d[r*3 + 1] = sr_q[r*3 + 2];
      end
      sr_d[2] = lb1_q[col_q];
      sr_d[5] = lb0_q[col_q];
      sr_d[8] = Data_In;

      if (col_end_c) begin
        col_d    = '0;
        col_ph_d = 1'b0;
        if (row_end_c) begin
          row_d    = '0;
          row_ph_d = 1'b0;
        end else begin
          row_d    = row_q + ROW_W'(1);
          row_ph_d = ~row_ph_q;
        end
      end else begin
        col_d    = col_q + COL_W'(1);
        col_ph_d = ~col_ph_q;
      end

      if (win_ok_c) begin
        valid_d = 1'b1;
        dout_d  = sr_d;
      end
      done_d = col_end_c && row_end_c;
    end
  end

  // State registers; reset beats a simultaneous valid pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      col_ph_q <= 1'b0;
      row_ph_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        sr_q[k]   <= '0;
        dout_q[k] <= '0;
      end
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      col_ph_q <= col_ph_d;
      row_ph_q <= row_ph_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      sr_q     <= sr_d;
      dout_q   <= dout_d;
    end
  end

  // Line-buffer RAM: not reset; row gating hides stale contents.
  always_ff @(posedge clk) begin
    if (Valid_In && !rst) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= Data_In;
    end
  end

  if ((STRIDE != 1) && (STRIDE != 2)) begin : g_bad_stride
    always @(posedge clk) begin
      $error("window_gen_3x3: unsupported STRIDE %0d", STRIDE);
    end
  end

  assign Data_Out0  = dout_q[0];
  assign Data_Out1  = dout_q[1];
  assign Data_Out2  = dout_q[2];
  assign Data_Out3  = dout_q[3];
  assign Data_Out4  = dout_q[4];
  assign Data_Out5  = dout_q[5];
  assign Data_Out6  = dout_q[6];
  assign Data_Out7  = dout_q[7];
  assign Data_Out8  = dout_q[8];
  assign Valid_Out  = valid_q;
  assign Frame_Done = done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed bench for window_gen_3x3 on a 5x5 image.
// Two instances (STRIDE=1 and STRIDE=2) share one input stream; monitors
// collect every published window, and each test task checks the collection.
module tb_window_gen_3x3;

  localparam int unsigned DW = 32;
  localparam int W = 5;
  localparam int H = 5;
  localparam logic [31:0] MARK = 32'h420070a4;

  typedef struct packed {
    logic [31:0]         cyc;
    logic                fd;
    logic [8:0][DW-1:0]  taps;
  } win_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          vin;
  logic [DW-1:0] din;
  logic [DW-1:0] s1_d [9];
  logic [DW-1:0] s2_d [9];
  logic          s1_v, s1_fd, s2_v, s2_fd;

  logic [31:0]   cyc = '0;
  logic          vin_seen = 1'b0;
  win_t          q1[$];
  win_t          q2[$];
  int            spurious = 0;
  int            fd_alone = 0;
  int            n_pass = 0;
  int            n_total = 0;

  always #5 clk = ~clk;

  window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst), .Data_In(din), .Valid_In(vin),
    .Data_Out0(s1_d[0]), .Data_Out1(s1_d[1]), .Data_Out2(s1_d[2]),
    .Data_Out3(s1_d[3]), .Data_Out4(s1_d[4]), .Data_Out5(s1_d[5]),
    .Data_Out6(s1_d[6]), .Data_Out7(s1_d[7]), .Data_Out8(s1_d[8]),
    .Valid_Out(s1_v), .Frame_Done(s1_fd)
  );

  window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .STRIDE(2)) u_s2 (
    .clk(clk), .rst(rst), .Data_In(din), .Valid_In(vin),
    .Data_Out0(s2_d[0]), .Data_Out1(s2_d[1]), .Data_Out2(s2_d[2]),
    .Data_Out3(s2_d[3]), .Data_Out4(s2_d[4]), .Data_Out5(s2_d[5]),
    .Data_Out6(s2_d[6]), .Data_Out7(s2_d[7]), .Data_Out8(s2_d[8]),
    .Valid_Out(s2_v), .Frame_Done(s2_fd)
  );

  always @(posedge clk) begin
    cyc      <= cyc + 32'd1;
    vin_seen <= vin && !rst;
  end

  // Window monitors, sampled on the falling edge.
  always @(negedge clk) begin : mon
    win_t w;
    if (s1_v) begin
      w.cyc = cyc;
      w.fd  = s1_fd;
      for (int k = 0; k < 9; k++) w.taps[k] = s1_d[k];
      q1.push_back(w);
    end
    if (s2_v) begin
      w.cyc = cyc;
      w.fd  = s2_fd;
      for (int k = 0; k < 9; k++) w.taps[k] = s2_d[k];
      q2.push_back(w);
    end
    if ((s1_v || s2_v) && !vin_seen) spurious++;
    if ((s1_fd && !s1_v) || (s2_fd && !s2_v)) fd_alone++;
  end

  // Expected taps for the window whose top-left pixel is (r0,c0).
  function automatic logic [8:0][DW-1:0] exp_win(input int base, input int r0, input int c0);
    logic [8:0][DW-1:0] e;
    for (int k = 0; k < 9; k++) e[k] = DW'(base + (r0 + k / 3) * W + c0 + k % 3);
    return e;
  endfunction

  // FP32 ordering for finite values (sign-magnitude).
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  task automatic drive_pixel(input logic [DW-1:0] v);
    @(posedge clk); #1;
    din = v;
    vin = 1'b1;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    vin = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input int gap_every, input int gap_len,
                            output logic [31:0] t12);
    t12 = '0;
    for (int i = 0; i < W * H; i++) begin
      drive_pixel(DW'(base + i));
      if (i == 12) t12 = cyc + 32'd1;
      if (gap_every != 0 && (i % gap_every) == gap_every - 1) idle(gap_len);
    end
  endtask

  task automatic clear_q();
    q1.delete();
    q2.delete();
    spurious = 0;
    fd_alone = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vin = 1'b1;
    din = 32'd77;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) begin
      n_total++;
      if (s1_d[k] !== 32'd0) $display("FAIL reset_tap%0d: got %h expected 0", k, s1_d[k]);
      else n_pass++;
    end
    n_total++;
    if ({s1_v, s1_fd, s2_v, s2_fd} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {s1_v, s1_fd, s2_v, s2_fd});
    else n_pass++;
    rst = 1'b0;
    vin = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stride1();
    logic [31:0] t12;
    clear_q();
    send_frame(0, 0, 0, t12);
    idle(3);
    n_total++;
    if (q1.size() != 9) $display("FAIL s1_count: got %0d expected 9", q1.size());
    else n_pass++;
    for (int n = 0; n < q1.size() && n < 9; n++) begin
      n_total++;
      if (q1[n].taps !== exp_win(0, n / 3, n % 3))
        $display("FAIL s1_win%0d: got %h expected %h", n, q1[n].taps, exp_win(0, n / 3, n % 3));
      else n_pass++;
      n_total++;
      if (q1[n].fd !== (n == 8))
        $display("FAIL s1_fd%0d: got %b expected %b", n, q1[n].fd, n == 8);
      else n_pass++;
    end
    if (q1.size() > 0) begin
      n_total++;
      if (q1[0].cyc !== t12) $display("FAIL s1_latency: got cycle %0d expected %0d", q1[0].cyc, t12);
      else n_pass++;
    end
    n_total++;
    if (fd_alone != 0) $display("FAIL s1_fd_alone: got %0d expected 0", fd_alone);
    else n_pass++;
  endtask

  task automatic test_stride2();
    logic [31:0] t12;
    clear_q();
    send_frame(0, 0, 0, t12);
    idle(3);
    n_total++;
    if (q2.size() != 4) $display("FAIL s2_count: got %0d expected 4", q2.size());
    else n_pass++;
    for (int n = 0; n < q2.size() && n < 4; n++) begin
      n_total++;
      if (q2[n].taps !== exp_win(0, (n / 2) * 2, (n % 2) * 2))
        $display("FAIL s2_win%0d: got %h expected %h", n, q2[n].taps,
                 exp_win(0, (n / 2) * 2, (n % 2) * 2));
      else n_pass++;
      n_total++;
      if (q2[n].fd !== (n == 3))
        $display("FAIL s2_fd%0d: got %b expected %b", n, q2[n].fd, n == 3);
      else n_pass++;
    end
    if (q2.size() > 0) begin
      n_total++;
      if (q2[0].cyc !== t12) $display("FAIL s2_latency: got cycle %0d expected %0d", q2[0].cyc, t12);
      else n_pass++;
    end
  endtask

  task automatic test_gaps();
    logic [31:0] t12;
    clear_q();
    send_frame(0, 4, 3, t12);
    idle(3);
    n_total++;
    if (q1.size() != 9) $display("FAIL gap_count: got %0d expected 9", q1.size());
    else n_pass++;
    for (int n = 0; n < q1.size() && n < 9; n++) begin
      n_total++;
      if (q1[n].taps !== exp_win(0, n / 3, n % 3) || q1[n].fd !== (n == 8))
        $display("FAIL gap_win%0d: got %h/%b expected %h/%b", n, q1[n].taps, q1[n].fd,
                 exp_win(0, n / 3, n % 3), n == 8);
      else n_pass++;
    end
    n_total++;
    if (q2.size() != 4) $display("FAIL gap_s2_count: got %0d expected 4", q2.size());
    else n_pass++;
    n_total++;
    if (spurious != 0) $display("FAIL gap_spurious: got %0d expected 0", spurious);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] t12;
    int base;
    clear_q();
    send_frame(0, 0, 0, t12);
    send_frame(100, 0, 0, t12);
    idle(3);
    n_total++;
    if (q1.size() != 18) $display("FAIL b2b_count: got %0d expected 18", q1.size());
    else n_pass++;
    for (int n = 0; n < q1.size() && n < 18; n++) begin
      base = (n < 9) ? 0 : 100;
      n_total++;
      if (q1[n].taps !== exp_win(base, (n % 9) / 3, n % 3) || q1[n].fd !== ((n % 9) == 8))
        $display("FAIL b2b_win%0d: got %h/%b expected %h/%b", n, q1[n].taps, q1[n].fd,
                 exp_win(base, (n % 9) / 3, n % 3), (n % 9) == 8);
      else n_pass++;
    end
    n_total++;
    if (q2.size() != 8) $display("FAIL b2b_s2_count: got %0d expected 8", q2.size());
    else n_pass++;
    if (q2.size() > 4) begin
      n_total++;
      if (q2[4].taps !== exp_win(100, 0, 0))
        $display("FAIL b2b_s2_first: got %h expected %h", q2[4].taps, exp_win(100, 0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] t12;
    clear_q();
    for (int i = 0; i <= 17; i++) drive_pixel(DW'(i));
    @(posedge clk); #1;
    rst = 1'b1;
    vin = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    send_frame(0, 0, 0, t12);
    idle(3);
    n_total++;
    if (q1.size() != 9) $display("FAIL rstmid_count: got %0d expected 9", q1.size());
    else n_pass++;
    if (q1.size() > 0) begin
      n_total++;
      if (q1[0].cyc !== t12) $display("FAIL rstmid_first: got cycle %0d expected %0d", q1[0].cyc, t12);
      else n_pass++;
    end
    for (int n = 0; n < q1.size() && n < 9; n++) begin
      n_total++;
      if (q1[n].taps !== exp_win(0, n / 3, n % 3))
        $display("FAIL rstmid_win%0d: got %h expected %h", n, q1[n].taps, exp_win(0, n / 3, n % 3));
      else n_pass++;
    end
    n_total++;
    if (q2.size() != 4) $display("FAIL rstmid_s2_count: got %0d expected 4", q2.size());
    else n_pass++;
  endtask

  task automatic test_max_marker();
    logic [31:0] mx;
    clear_q();
    for (int i = 0; i < W * H; i++)
      drive_pixel((i == 12) ? MARK : (32'hC0000000 + 32'(i)));
    idle(3);
    n_total++;
    if (q1.size() + q2.size() != 13)
      $display("FAIL max_count: got %0d expected 13", q1.size() + q2.size());
    else n_pass++;
    for (int n = 0; n < q1.size() + q2.size(); n++) begin
      win_t w;
      w  = (n < q1.size()) ? q1[n] : q2[n - q1.size()];
      mx = w.taps[0];
      for (int k = 1; k < 9; k++) if (fp_gt(w.taps[k], mx)) mx = w.taps[k];
      n_total++;
      if (mx !== MARK) $display("FAIL max_win%0d: got %h expected %h", n, mx, MARK);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    vin = 1'b0;
    din = '0;
    test_reset();
    test_stride1();
    test_stride2();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
    test_max_marker();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
